// File: rtl/alsu_driver.sv
// Request-side controller for the ALSU: issues one request per accepted handshake
// onto registered ALSU pins and returns the tagged result through a credit-guarded FIFO.
module alsu_driver #(
  parameter int ALSU_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_opcode,
  input  logic [2:0]  req_a,
  input  logic [2:0]  req_b,
  input  logic [6:0]  req_flags,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  output logic        alsu_direction,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic [2:0]  alsu_opcode,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_out,
  output logic [15:0] rsp_leds,
  output logic        rsp_invalid,
  output logic [2:0]  rsp_opcode,
  output logic        busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NSTG = ALSU_LATENCY + 1;
  localparam int CW   = $clog2(FIFO_DEPTH + NSTG + 2) + 1;

  typedef struct packed {
    logic       v;
    logic       inv;
    logic [2:0] op;
  } tag_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [6:0] flags;
  } pins_t;

  typedef struct packed {
    logic [5:0]  out;
    logic [15:0] leds;
    logic        inv;
    logic [2:0]  op;
  } rsp_t;

  logic          r_init;
  pins_t         r_pins;
  tag_t          r_pin_tag;
  tag_t          r_pipe [NSTG];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  rsp_t          r_mem [FIFO_DEPTH];

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_invalid;
  logic [CW-1:0] w_inflight;
  logic [CW-1:0] w_used;
  rsp_t          w_head;

  // Credits come only from registered counts, so req_ready never sees req_valid or rsp_ready.
  always_comb begin
    w_inflight = CW'(r_pin_tag.v);
    for (int i = 0; i < NSTG; i++) w_inflight = w_inflight + CW'(r_pipe[i].v);
    w_used = w_inflight + CW'(r_count);
  end

  assign req_ready = r_init && (w_used < CW'(FIFO_DEPTH));
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_count != '0);
  assign w_push    = r_pipe[NSTG-1].v;
  assign w_pop     = rsp_valid && rsp_ready;
  assign busy      = (w_inflight != '0) || rsp_valid;

  // op[2]^op[1] selects the arithmetic/shift opcodes 010..101, where reduction is illegal.
  assign w_invalid = !req_flags[2] && !req_flags[1] &&
                     ((req_opcode[2:1] == 2'b11) ||
                      ((req_opcode[2] ^ req_opcode[1]) && (req_flags[4] || req_flags[3])));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init    <= 1'b0;
      r_pins    <= '0;
      r_pin_tag <= '0;
      for (int i = 0; i < NSTG; i++) r_pipe[i] <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_accept) begin
        r_pins    <= '{op: req_opcode, a: req_a, b: req_b, flags: req_flags};
        r_pin_tag <= '{v: 1'b1, inv: w_invalid, op: req_opcode};
      end else begin
        r_pins    <= '0;
        r_pin_tag <= '0;
      end
      r_pipe[0] <= r_pin_tag;
      for (int i = 1; i < NSTG; i++) r_pipe[i] <= r_pipe[i-1];
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{out: alsu_out, leds: alsu_leds,
                                   inv: r_pipe[NSTG-1].inv, op: r_pipe[NSTG-1].op};
  end

  assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == (AW+1)'(FIFO_DEPTH))));

  assign w_head = rsp_valid ? r_mem[r_rptr] : '0;

  assign rsp_out     = w_head.out;
  assign rsp_leds    = w_head.leds;
  assign rsp_invalid = w_head.inv;
  assign rsp_opcode  = w_head.op;

  assign alsu_opcode = r_pins.op;
  assign alsu_A      = r_pins.a;
  assign alsu_B      = r_pins.b;
  assign {alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B,
          alsu_bypass_A, alsu_bypass_B, alsu_direction} = r_pins.flags;

endmodule
